// File: rtl/spi_slave_ctrl_pkg.sv
// spi_slave_ctrl_pkg: shared SPI command encodings, transfer limits and mode/state types.
package spi_slave_ctrl_pkg;
    localparam logic [7:0] READ_CMD         = 8'h00;
    localparam logic [7:0] WRITE_CMD        = 8'h40;
    localparam logic [7:0] READMULT_CMD     = 8'h80;
    localparam logic [7:0] WRITEMULT_CMD    = 8'hC0;
    localparam logic [7:0] CMD_BITMASK      = 8'hC0;
    localparam int         MAX_SPI_XACTIONS = 256;
    localparam bit         CPOL             = 1'b0;
    localparam bit         CPHA             = 1'b1;

    typedef enum logic [2:0] {
        SPI_MODE_NULL,
        SPI_MODE_READ,
        SPI_MODE_WRITE,
        SPI_MODE_READMULT,
        SPI_MODE_WRITEMULT
    } spi_mode_t;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_IGNORE} spi_state_t;

    // Any bit outside the command mask makes the command invalid.
    function automatic spi_mode_t spi_decode(input logic [7:0] i_cmd);
        logic [7:0] w_c;
        w_c = i_cmd & CMD_BITMASK;
        return ((i_cmd & ~CMD_BITMASK) != 8'd0) ? SPI_MODE_NULL      :
               (w_c == READ_CMD)                ? SPI_MODE_READ      :
               (w_c == WRITE_CMD)               ? SPI_MODE_WRITE     :
               (w_c == READMULT_CMD)            ? SPI_MODE_READMULT  :
               (w_c == WRITEMULT_CMD)           ? SPI_MODE_WRITEMULT : SPI_MODE_NULL;
    endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer with rise/fall pulses; edges are suppressed until
// the chain holds real pin samples, so a level present at reset release is not an edge.
module spi_sync #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic [STAGES:0]   r_vld;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_vld  <= {r_vld[STAGES-1:0], 1'b1};
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_vld[STAGES] & o_q & ~r_prev;
    assign o_fall = r_vld[STAGES] & ~o_q & r_prev;
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave (CPOL=0, CPHA=1, MSB first) turning command/address/data
// frames into one-clk register bus read/write strobes.
module spi_slave_ctrl
    import spi_slave_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output spi_mode_t  mode,
    output logic       busy
);
    logic       w_unused_sclk, w_unused_mosi_rise, w_unused_mosi_fall;
    logic       w_sclk_rise, w_sclk_fall, w_cs, w_cs_rise, w_cs_fall, w_mosi;
    logic       w_sample, w_drive, w_rd, w_wr, w_mult, w_last;
    logic [7:0] w_byte;
    spi_mode_t  w_cmd_mode;
    spi_state_t r_state;
    spi_mode_t  r_mode;
    logic [2:0] r_bit_cnt;
    logic [8:0] r_xact_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_miso_sr, r_addr, r_wdata;
    logic       r_we, r_re, r_load, r_miso, r_miso_oe;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk),
        .o_q(w_unused_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_d(cs_n),
        .o_q(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_d(mosi),
        .o_q(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall));

    assign w_sample   = (CPOL ^ CPHA) ? w_sclk_fall : w_sclk_rise;
    assign w_drive    = (CPOL ^ CPHA) ? w_sclk_rise : w_sclk_fall;
    assign w_byte     = {r_shift, w_mosi};
    assign w_cmd_mode = spi_decode(w_byte);
    assign w_rd       = (r_mode == SPI_MODE_READ) || (r_mode == SPI_MODE_READMULT);
    assign w_wr       = (r_mode == SPI_MODE_WRITE) || (r_mode == SPI_MODE_WRITEMULT);
    assign w_mult     = (r_mode == SPI_MODE_READMULT) || (r_mode == SPI_MODE_WRITEMULT);
    assign w_last     = (r_xact_cnt + 9'd1) == (w_mult ? 9'(MAX_SPI_XACTIONS) : 9'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= SPI_MODE_NULL;
            r_bit_cnt  <= '0;
            r_xact_cnt <= '0;
            r_shift    <= '0;
            r_miso_sr  <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_load     <= 1'b0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_load    <= r_re;
            r_miso_oe <= ~w_cs;
            if (r_load) begin
                r_miso_sr <= reg_rdata;
                r_miso    <= reg_rdata[7];
            end
            // Write address advances only after its strobe so it is stable during reg_we.
            if (r_we && w_mult)
                r_addr <= r_addr + 8'd1;
            if (w_cs_rise) begin
                r_state <= ST_IDLE;
                r_mode  <= SPI_MODE_NULL;
                r_miso  <= 1'b0;
            end else if (w_cs_fall) begin
                r_state    <= ST_CMD;
                r_mode     <= SPI_MODE_NULL;
                r_bit_cnt  <= '0;
                r_xact_cnt <= '0;
                r_miso     <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (w_drive)
                    r_miso <= (r_state == ST_DATA && w_rd) ? r_miso_sr[~r_bit_cnt] : 1'b0;
                if (w_sample) begin
                    r_shift   <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        case (r_state)
                            ST_CMD: begin
                                r_mode  <= w_cmd_mode;
                                r_state <= (w_cmd_mode == SPI_MODE_NULL) ? ST_IGNORE : ST_ADDR;
                            end
                            ST_ADDR: begin
                                r_addr  <= w_byte;
                                r_re    <= w_rd;
                                r_state <= ST_DATA;
                            end
                            ST_DATA: begin
                                r_xact_cnt <= r_xact_cnt + 9'd1;
                                if (w_wr) begin
                                    r_wdata <= w_byte;
                                    r_we    <= 1'b1;
                                end
                                if (w_last)
                                    r_state <= ST_IGNORE;
                                else if (w_rd) begin
                                    r_addr <= r_addr + 8'd1;
                                    r_re   <= 1'b1;
                                end
                            end
                            default: r_state <= r_state;
                        endcase
                    end
                end
            end
        end
    end

    assign miso      = r_miso;
    assign miso_oe   = r_miso_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign mode      = r_mode;
    assign busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed vector table for single transfers plus hand-written
// sequences for address wrap, READMULT limit, mid-byte abort and reset-release.
module tb_spi_slave_ctrl;
    import spi_slave_ctrl_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       miso, miso_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    spi_mode_t  mode;

    logic [7:0] mem [256];
    assign reg_rdata = mem[reg_addr];

    spi_slave_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .mode(mode), .busy(busy));

    always #5 clk = ~clk;

    int         checks = 0, errors = 0;
    int         n_we = 0, n_re = 0;
    bit         both = 1'b0;
    logic [7:0] we_a [8], we_d [8], re_a [300];

    always @(negedge clk) begin
        if (reg_we) begin
            if (n_we < 8) begin
                we_a[n_we] = reg_addr;
                we_d[n_we] = reg_wdata;
            end
            n_we++;
        end
        if (reg_re) begin
            if (n_re < 300) re_a[n_re] = reg_addr;
            n_re++;
        end
        if (reg_we && reg_re) both = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Master side of CPHA=1: drive mosi on the rising edge, sample miso on the falling edge.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            sclk = 1'b1;
            #80;
            sclk = 1'b0;
            rx[i] = miso;
            #80;
        end
    endtask

    typedef struct {
        logic [7:0] cmd, addr, d0, d1;
        bit         two;
        spi_mode_t  m;
        int         nwe, nre;
        logic [7:0] ea, ewd, rx0, rx1;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] rx, rx0, rx1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h34] = 8'h3C;
        vecs[0] = '{8'h40, 8'h12, 8'hA5, 8'h00, 1'b0, SPI_MODE_WRITE, 1, 0, 8'h12, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{8'h00, 8'h34, 8'hFF, 8'h00, 1'b0, SPI_MODE_READ,  0, 1, 8'h34, 8'h00, 8'h3C, 8'h00};
        vecs[2] = '{8'h41, 8'h12, 8'hA5, 8'h00, 1'b0, SPI_MODE_NULL,  0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{8'h40, 8'h00, 8'hFF, 8'h00, 1'b0, SPI_MODE_WRITE, 1, 0, 8'h00, 8'hFF, 8'h00, 8'h00};
        vecs[4] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, SPI_MODE_READ,  0, 1, 8'hFF, 8'h00, 8'hA5, 8'h00};
        vecs[5] = '{8'h01, 8'h55, 8'hAA, 8'h00, 1'b0, SPI_MODE_NULL,  0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{8'h40, 8'h20, 8'h5A, 8'hC3, 1'b1, SPI_MODE_WRITE, 1, 0, 8'h20, 8'h5A, 8'h00, 8'h00};
        vecs[7] = '{8'h00, 8'h10, 8'hFF, 8'hFF, 1'b1, SPI_MODE_READ,  0, 1, 8'h10, 8'h00, 8'h4A, 8'h00};

        #23;
        chk("rst_we", reg_we, 0);
        chk("rst_re", reg_re, 0);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mode", mode, SPI_MODE_NULL);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        #20 rst_n = 1'b1;
        #200;

        for (int v = 0; v < 8; v++) begin
            n_we = 0;
            n_re = 0;
            cs_n = 1'b0;
            #80;
            spi_bits(vecs[v].cmd, 8, rx);
            chk($sformatf("v%0d_mode", v), mode, vecs[v].m);
            chk($sformatf("v%0d_miso_oe", v), miso_oe, 1);
            chk($sformatf("v%0d_busy", v), busy, 1);
            spi_bits(vecs[v].addr, 8, rx);
            spi_bits(vecs[v].d0, 8, rx0);
            rx1 = 8'h00;
            if (vecs[v].two) spi_bits(vecs[v].d1, 8, rx1);
            #80 cs_n = 1'b1;
            #160;
            chk($sformatf("v%0d_n_we", v), n_we, vecs[v].nwe);
            chk($sformatf("v%0d_n_re", v), n_re, vecs[v].nre);
            if (vecs[v].nwe > 0) begin
                chk($sformatf("v%0d_we_addr", v), we_a[0], vecs[v].ea);
                chk($sformatf("v%0d_wdata", v), we_d[0], vecs[v].ewd);
            end
            if (vecs[v].nre > 0) chk($sformatf("v%0d_re_addr", v), re_a[0], vecs[v].ea);
            chk($sformatf("v%0d_rx0", v), rx0, vecs[v].rx0);
            if (vecs[v].two) chk($sformatf("v%0d_rx1", v), rx1, vecs[v].rx1);
            chk($sformatf("v%0d_busy_end", v), busy, 0);
            chk($sformatf("v%0d_mode_end", v), mode, SPI_MODE_NULL);
        end

        // WRITEMULT address wrap FE -> FF -> 00
        n_we = 0;
        cs_n = 1'b0;
        #80;
        spi_bits(8'hC0, 8, rx);
        chk("wm_mode", mode, SPI_MODE_WRITEMULT);
        spi_bits(8'hFE, 8, rx);
        spi_bits(8'h11, 8, rx);
        spi_bits(8'h22, 8, rx);
        spi_bits(8'h33, 8, rx);
        #80 cs_n = 1'b1;
        #160;
        chk("wm_n_we", n_we, 3);
        chk("wm_a0", we_a[0], 8'hFE);
        chk("wm_a1", we_a[1], 8'hFF);
        chk("wm_a2", we_a[2], 8'h00);
        chk("wm_d0", we_d[0], 8'h11);
        chk("wm_d1", we_d[1], 8'h22);
        chk("wm_d2", we_d[2], 8'h33);

        // READMULT limit: the address-byte read plus 255 prefetches gives exactly 256
        // reg_re; no prefetch follows data byte 256, and byte 257 reads 00.
        n_re = 0;
        cs_n = 1'b0;
        #80;
        spi_bits(8'h80, 8, rx);
        chk("rm_mode", mode, SPI_MODE_READMULT);
        spi_bits(8'h00, 8, rx);
        for (int i = 0; i < 257; i++) begin
            spi_bits(8'(i), 8, rx);
            chk($sformatf("rm_rx%0d", i), rx, (i < 256) ? mem[i] : 8'h00);
        end
        #80 cs_n = 1'b1;
        #160;
        chk("rm_n_re", n_re, 256);
        for (int k = 0; k < 256; k++) chk($sformatf("rm_re_addr%0d", k), re_a[k], k);

        // Abort after 5 bits of a WRITE data byte
        n_we = 0;
        cs_n = 1'b0;
        #80;
        spi_bits(8'h40, 8, rx);
        spi_bits(8'h12, 8, rx);
        spi_bits(8'hA5, 5, rx);
        chk("ab_mode_mid", mode, SPI_MODE_WRITE);
        #40 cs_n = 1'b1;
        #160;
        chk("ab_n_we", n_we, 0);
        chk("ab_busy", busy, 0);
        chk("ab_mode", mode, SPI_MODE_NULL);

        // cs_n already low across reset: the transfer must be ignored until a new falling edge
        cs_n = 1'b0;
        #40 rst_n = 1'b0;
        #40 rst_n = 1'b1;
        #200;
        n_we = 0;
        spi_bits(8'h40, 8, rx);
        spi_bits(8'h12, 8, rx);
        spi_bits(8'hA5, 8, rx);
        chk("rr_busy", busy, 0);
        chk("rr_mode", mode, SPI_MODE_NULL);
        #80;
        chk("rr_n_we", n_we, 0);
        cs_n = 1'b1;
        #160;
        cs_n = 1'b0;
        #80;
        spi_bits(8'h40, 8, rx);
        spi_bits(8'h77, 8, rx);
        spi_bits(8'h3C, 8, rx);
        #80 cs_n = 1'b1;
        #160;
        chk("rr_n_we_after", n_we, 1);
        chk("rr_we_addr", we_a[0], 8'h77);
        chk("rr_wdata", we_d[0], 8'h3C);

        chk("we_re_exclusive", both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for sclk/cs_n/mosi (minimum 2).
REQ-002 SHALL have port clk  in  1  system clock; clk frequency >= 8x SCLK.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports sclk, cs_n, mosi  in  1 each  raw SPI pins, asynchronous to clk.
REQ-005 SHALL have ports miso  out  1 (serial data) and miso_oe  out  1 (high while synchronized cs_n is low).
REQ-006 SHALL have ports reg_addr  out  8 (register address) and reg_wdata  out  8 (write data).
REQ-007 SHALL have ports reg_we  out  1 (one-clk write strobe) and reg_re  out  1 (one-clk read strobe).
REQ-008 SHALL have port reg_rdata  in  8, valid exactly 1 clk after reg_re.
REQ-009 SHALL have ports mode  out  spi_mode_t (decoded command, SPI_MODE_NULL when idle/invalid) and busy  out  1 (FSM not IDLE).

Function
REQ-010 SHALL use SPI mode CPOL=0, CPHA=1, MSB first: sample mosi on synchronized sclk falling edge, update miso on rising edge.
REQ-011 SHALL frame transactions as byte0 = command, byte1 = address, bytes 2..N = data.
REQ-012 SHALL decode command (byte0 AND CMD_BITMASK): READ_CMD->READ, WRITE_CMD->WRITE, READMULT_CMD->READMULT, WRITEMULT_CMD->WRITEMULT.
REQ-013 SHALL treat a command with any of bits [5:0] nonzero as invalid: mode = NULL, go to IGNORE, no bus strobes, miso = 0.
REQ-014 SHALL implement FSM states IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE->CMD: cs_n falling edge.
  - CMD->ADDR: 8th bit, valid command.
  - ADDR->DATA: 8th bit.
  - DATA->IGNORE: transaction limit reached.
  - any state->IDLE: cs_n rising edge.
REQ-015 SHALL track bit position with a 3-bit counter reset on cs_n falling edge, and data bytes with a 9-bit counter (0..MAX_SPI_XACTIONS).
REQ-016 SHALL for WRITE modes pulse reg_we for one clk, 1-2 clks after the 8th falling edge of each data byte, with reg_addr/reg_wdata stable during the pulse.
REQ-017 SHALL for READ modes pulse reg_re once on completion of the address byte, load reg_rdata into the MISO shift register one clk later, and present bit7 before the first rising edge of the next byte.
REQ-018 SHALL for READMULT issue the next reg_re after the 8th falling edge of each data byte (prefetch), address incremented.
REQ-019 SHALL for *MULT modes increment reg_addr after each data byte, wrapping 8'hFF->8'h00.
REQ-020 SHALL limit single modes to 1 data byte and MULT modes to MAX_SPI_XACTIONS data bytes; further bytes SHALL be ignored with no strobes and miso = 0.
REQ-021 SHALL drive miso = 0 during CMD, ADDR and IGNORE.
REQ-022 SHALL on cs_n rising mid-byte discard the partial byte, issue no strobe, and return to IDLE with mode = NULL.
REQ-023 SHALL never assert reg_we and reg_re in the same clk.

Reset
REQ-024 SHALL on rst_n low asynchronously force: FSM IDLE, counters 0, reg_addr 0, reg_wdata 0, reg_we 0, reg_re 0, miso 0, miso_oe 0, mode NULL, busy 0, synchronizers to idle levels (sclk 0, cs_n 1).
REQ-025 SHALL after reset release ignore any transfer whose cs_n falling edge was not observed, until the next cs_n falling edge.

Structure
REQ-026 SHALL take CMD_* constants, CMD_BITMASK, MAX_SPI_XACTIONS, CPOL/CPHA and spi_mode_t from the shared SPI package; no local redefinition.
REQ-027 SHALL instantiate one sub-module spi_sync per input pin (SYNC_STAGES-flop synchronizer with rise/fall pulse outputs).

Verification
REQ-028 SHALL verify WRITE: bytes 40,12,A5 -> one reg_we with addr 12, wdata A5; mode WRITE.
REQ-029 SHALL verify READ: bytes 00,34,xx with reg_rdata=3C -> one reg_re at addr 34; miso returns 3C MSB-first.
REQ-030 SHALL verify WRITEMULT wrap: C0,FE then 3 data bytes -> reg_we at addrs FE, FF, 00.
REQ-031 SHALL verify READMULT limit: 80,00 then 257 bytes -> exactly 256 reg_re (257 if prefetch counted, documented), byte 257 reads 00.
REQ-032 SHALL verify invalid command and abort: byte 41 -> mode NULL, no strobes; cs_n raised after 5 bits of a WRITE data byte -> no reg_we, busy 0.
